// File: rtl/data_bus_decoder_if.sv
// Data-side sram bus between the core, the MMIO decoder and the data RAM.
// master = core plus RAM environment, slave = the decoder itself.
interface data_bus_decoder_if;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        ram_en;
   logic [3:0]  ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   modport master (
      output cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata,
      input  cpu_rdata, ram_en, ram_wen, ram_addr, ram_wdata
   );

   modport slave (
      input  cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata,
      output cpu_rdata, ram_en, ram_wen, ram_addr, ram_wdata
   );
endinterface

// File: rtl/data_bus_decoder.sv
// Splits core data accesses between on-chip MMIO registers and the data RAM.
// Read data returns one cycle after the request on both paths; no backpressure, one access per cycle.
module data_bus_decoder #(
   parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
   parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
   input  logic                 clk,
   input  logic                 resetn,
   data_bus_decoder_if.slave    bus,
   input  logic [7:0]           switch,
   output logic [15:0]          led,
   output logic [31:0]          num_data,
   output logic                 timer_irq
);

   localparam logic [15:0] OFF_LED    = 16'h0000;
   localparam logic [15:0] OFF_SWITCH = 16'h0004;
   localparam logic [15:0] OFF_TIMER  = 16'h0008;
   localparam logic [15:0] OFF_CMP    = 16'h000c;
   localparam logic [15:0] OFF_STATUS = 16'h0010;
   localparam logic [15:0] OFF_NUM    = 16'h0014;

   logic [15:0] led_q, led_d;
   logic [7:0]  sw_meta_q, sw_sync_q;
   logic [31:0] timer_q, timer_d;
   logic [31:0] cmp_q, cmp_d;
   logic        irq_q, irq_d;
   logic [31:0] num_q, num_d;
   logic        sel_q, sel_d;
   logic [31:0] conf_q, conf_d;

   logic        hit;
   logic [15:0] offset;
   logic        wr_en;
   logic        match;
   logic        w1c;
   logic [31:0] rd_val;

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   // Address decode and RAM pass-through; RAM never sees window hits.
   always_comb begin
      hit           = (bus.cpu_addr & CONF_MASK) == (CONF_BASE & CONF_MASK);
      offset        = bus.cpu_addr[15:0];
      wr_en         = bus.cpu_en & hit & (|bus.cpu_wen);
      bus.ram_en    = bus.cpu_en & ~hit;
      bus.ram_wen   = hit ? 4'h0 : bus.cpu_wen;
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
   end

   always_comb begin
      rd_val = 32'h0;
      case (offset)
         OFF_LED:    rd_val = {16'h0, led_q};
         OFF_SWITCH: rd_val = {24'h0, sw_sync_q};
         OFF_TIMER:  rd_val = timer_q;
         OFF_CMP:    rd_val = cmp_q;
         OFF_STATUS: rd_val = {31'h0, irq_q};
         OFF_NUM:    rd_val = num_q;
         default:    rd_val = 32'h0;
      endcase
   end

   // Match uses the pre-increment, pre-write timer; a set beats a same-cycle clear.
   always_comb begin
      led_d   = led_q;
      timer_d = timer_q + 32'd1;
      cmp_d   = cmp_q;
      num_d   = num_q;
      match   = (timer_q == cmp_q);
      w1c     = wr_en && (offset == OFF_STATUS) && bus.cpu_wen[0] && bus.cpu_wdata[0];
      irq_d   = match | (irq_q & ~w1c);

      if (wr_en) begin
         case (offset)
            OFF_LED: begin
               led_d[7:0]  = bus.cpu_wen[0] ? bus.cpu_wdata[7:0]  : led_q[7:0];
               led_d[15:8] = bus.cpu_wen[1] ? bus.cpu_wdata[15:8] : led_q[15:8];
            end
            OFF_TIMER: timer_d = be_merge(timer_q, bus.cpu_wdata, bus.cpu_wen);
            OFF_CMP:   cmp_d   = be_merge(cmp_q,   bus.cpu_wdata, bus.cpu_wen);
            OFF_NUM:   num_d   = be_merge(num_q,   bus.cpu_wdata, bus.cpu_wen);
            default:   ;
         endcase
      end
   end

   // Read-path capture holds while the core is idle so cpu_rdata stays stable.
   always_comb begin
      sel_d  = sel_q;
      conf_d = conf_q;
      if (bus.cpu_en) begin
         sel_d  = hit;
         conf_d = rd_val;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_q     <= 16'h0;
         sw_meta_q <= 8'h0;
         sw_sync_q <= 8'h0;
         timer_q   <= 32'h0;
         cmp_q     <= 32'hffff_ffff;
         irq_q     <= 1'b0;
         num_q     <= 32'h0;
         sel_q     <= 1'b1;
         conf_q    <= 32'h0;
      end else begin
         led_q     <= led_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
         timer_q   <= timer_d;
         cmp_q     <= cmp_d;
         irq_q     <= irq_d;
         num_q     <= num_d;
         sel_q     <= sel_d;
         conf_q    <= conf_d;
      end
   end

   assign bus.cpu_rdata = sel_q ? conf_q : bus.ram_rdata;
   assign led           = led_q;
   assign num_data      = num_q;
   assign timer_irq     = irq_q;

endmodule
